// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU sequencer: ALU control codes,
// FSM state encoding and the latched-operation record.
package alu_share_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_MUL = 4'b0100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl;
    logic        id;
  } alu_op_t;

  function automatic logic is_supported(input logic [3:0] ctrl);
    case (ctrl)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB,
      CTRL_SLT, CTRL_NOR, CTRL_MUL: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Shared 32-bit combinational ALU. Unsupported control codes yield zero and
// raise err_o.
module alu_share_ctrl_alu
  import alu_share_pkg::*;
(
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [3:0]  ctrl_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        err_o
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives result_o;
    // otherwise an uncovered ctrl value would infer a latch.
    result_o = '0;
    case (ctrl_i)
      CTRL_AND: result_o = src1_i & src2_i;
      CTRL_OR:  result_o = src1_i | src2_i;
      CTRL_ADD: result_o = src1_i + src2_i;
      CTRL_SUB: result_o = src1_i - src2_i;
      CTRL_SLT: result_o = {31'd0, src1_i < src2_i};
      CTRL_NOR: result_o = ~(src1_i | src2_i);
      CTRL_MUL: result_o = src1_i * src2_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign err_o  = !is_supported(ctrl_i);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer in front of a single shared ALU: accept one
// operation, hold it for its per-opcode latency, return a tagged response.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [3:0]  req0_ctrl_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [3:0]  req1_ctrl_i,
  output logic        req1_ready_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_err_o
);

  localparam int CNT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] ALU_LOAD = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  alu_op_t       op_q, op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic          rsp_err_q, rsp_err_d;

  logic          any_valid, grant_id, accept;
  alu_op_t       req_op;
  logic [31:0]   alu_result;
  logic          alu_zero, alu_err;

  // With both requesters valid rr_ptr decides; otherwise the lone valid one wins.
  always_comb begin
    any_valid    = req0_valid_i | req1_valid_i;
    grant_id     = (req0_valid_i && req1_valid_i) ? rr_ptr_q : req1_valid_i;
    accept       = (state_q == ST_IDLE) && any_valid && !rst_i;
    req0_ready_o = accept && !grant_id;
    req1_ready_o = accept && grant_id;
    req_op       = grant_id ? '{src1: req1_src1_i, src2: req1_src2_i, ctrl: req1_ctrl_i, id: 1'b1}
                            : '{src1: req0_src1_i, src2: req0_src2_i, ctrl: req0_ctrl_i, id: 1'b0};
  end

  alu_share_ctrl_alu u_alu (
    .src1_i   (op_q.src1),
    .src2_i   (op_q.src2),
    .ctrl_i   (op_q.ctrl),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .err_o    (alu_err)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d     = req_op;
          cnt_d    = (req_op.ctrl == CTRL_MUL) ? MUL_LOAD : ALU_LOAD;
          rr_ptr_d = ~grant_id;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_err_d    = alu_err;
          rsp_id_d     = op_q.id;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        // Data outputs intentionally keep their values after the handshake.
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 1'b0;
      cnt_q        <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;

endmodule
